// File: rtl/udi_spect_pkg.sv
// ---------------------------------------------------------------------------
// udi_spect_pkg
//   Shared constants and types for the udi_spect_sched sequencer:
//   UDI major opcode, funct codes, datapath control encodings, the
//   sequencer FSM state encoding and the decoder output struct.
// ---------------------------------------------------------------------------
package udi_spect_pkg;

   // Instruction fields
   localparam logic [5:0] MAJ_OP   = 6'd28;   // SPECIAL2 major opcode (ir[31:26])
   localparam logic [5:0] FN_SUM   = 6'd16;   // rs.hi^2 + rt^2
   localparam logic [5:0] FN_SUMH  = 6'd17;   // (rs.hi^2 + rt^2) >> 1
   localparam logic [5:0] FN_BYP   = 6'd18;   // bypass
   localparam logic [5:0] FN_THR   = 6'd19;   // write compare threshold
   localparam logic [5:0] FN_CSUM  = 6'd20;   // compare of FN_SUM value
   localparam logic [5:0] FN_CSUMH = 6'd21;   // compare of FN_SUMH value
   localparam logic [5:0] FN_CBYP  = 6'd22;   // compare of bypass value
   localparam logic [5:0] FN_SDACC = 6'd23;   // two-pass accumulate of four squares

   // The SDACC sequence is built around exactly one extra M cycle.
   localparam int STALL_CYCLES = 1;

   // Datapath control encodings
   localparam logic [1:0] CTL_SUM_MODE_NONE = 2'd0;
   localparam logic [1:0] CTL_SUM_MODE_SUM  = 2'd1;
   localparam logic [1:0] CTL_SUM_MODE_HALF = 2'd2;
   localparam logic [1:0] CTL_SUM_MODE_BYP  = 2'd3;
   localparam logic       CTL_RES_CALC      = 1'b0;
   localparam logic       CTL_RES_COMP      = 1'b1;

   // Sequencer state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_P2   = 2'd1,
      ST_FIN  = 2'd2
   } sched_state_t;

   // Decoder output
   typedef struct packed {
      logic       load;       // funct is one of the mapped ops; mode regs load on hit
      logic       thr_wr;     // threshold write
      logic [1:0] sum_mode;
      logic       res_sel;
      logic       is_sdacc;
   } udi_dec_t;

endpackage

// File: rtl/udi_spect_sched_if.sv
// ---------------------------------------------------------------------------
// udi_spect_sched_if
//   M14K UDI core-side signal bundle for the udi_spect_sched sequencer.
//   master : the core (drives instruction, operands, pipeline controls)
//   slave  : the sequencer (returns M-stage result and stall request)
//
//   Pipeline handshake: an instruction is accepted in E only when
//   UDI_irvalid_e and UDI_start_e are both high in the same cycle. It
//   reaches M on the next cycle; while UDI_stall_m is high the core holds
//   M (and E) and consumes UDI_rd_m only in the first M cycle with
//   UDI_stall_m low. UDI_kill_m counts only when UDI_run_m is also high.
// ---------------------------------------------------------------------------
interface udi_spect_sched_if;
   logic [31:0] UDI_ir_e;
   logic        UDI_irvalid_e;
   logic        UDI_start_e;
   logic        UDI_run_m;
   logic        UDI_kill_m;
   logic [31:0] UDI_rs_e;
   logic [31:0] UDI_rt_e;
   logic [31:0] UDI_rd_m;
   logic        UDI_stall_m;

   modport master (
      output UDI_ir_e, UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m,
             UDI_rs_e, UDI_rt_e,
      input  UDI_rd_m, UDI_stall_m
   );

   modport slave (
      input  UDI_ir_e, UDI_irvalid_e, UDI_start_e, UDI_run_m, UDI_kill_m,
             UDI_rs_e, UDI_rt_e,
      output UDI_rd_m, UDI_stall_m
   );
endinterface

// File: rtl/mvp_cregister_wide.sv
// ---------------------------------------------------------------------------
// mvp_cregister_wide
//   Conditionally loaded register with scan enable. Loads d when cond is
//   high; scan enable forces a load so the register shifts in scan mode.
//   Ports: clk, cond (load enable), scanen, d[WIDTH], q[WIDTH].
// ---------------------------------------------------------------------------
module mvp_cregister_wide #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             cond,
   input  logic             scanen,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (cond | scanen) begin
         q <= d;
      end
   end
endmodule

// File: rtl/udi_spect_decode.sv
// ---------------------------------------------------------------------------
// udi_spect_decode
//   Combinational funct decode for the udi_spect datapath ops.
//   Ports: i_funct[6] in, o_dec (udi_dec_t) out.
//   Unmapped functs decode to all-zero (no action).
// ---------------------------------------------------------------------------
module udi_spect_decode
   import udi_spect_pkg::*;
(
   input  logic [5:0] i_funct,
   output udi_dec_t   o_dec
);
   always_comb begin
      o_dec = '0;
      case (i_funct)
         FN_SUM:   begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_SUM;  o_dec.res_sel = CTL_RES_CALC; end
         FN_SUMH:  begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_HALF; o_dec.res_sel = CTL_RES_CALC; end
         FN_BYP:   begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_BYP;  o_dec.res_sel = CTL_RES_CALC; end
         FN_THR:   begin o_dec.load = 1'b1; o_dec.thr_wr = 1'b1;
                         o_dec.sum_mode = CTL_SUM_MODE_NONE; o_dec.res_sel = CTL_RES_CALC; end
         FN_CSUM:  begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_SUM;  o_dec.res_sel = CTL_RES_COMP; end
         FN_CSUMH: begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_HALF; o_dec.res_sel = CTL_RES_COMP; end
         FN_CBYP:  begin o_dec.load = 1'b1; o_dec.sum_mode = CTL_SUM_MODE_BYP;  o_dec.res_sel = CTL_RES_COMP; end
         // First SDACC pass is a plain sum of the hi halves.
         FN_SDACC: begin o_dec.load = 1'b1; o_dec.is_sdacc = 1'b1;
                         o_dec.sum_mode = CTL_SUM_MODE_SUM; o_dec.res_sel = CTL_RES_CALC; end
         default:  ;
      endcase
   end
endmodule

// File: rtl/udi_spect_sched.sv
// ---------------------------------------------------------------------------
// udi_spect_sched
//   Sequencer between the M14K UDI port and the udi_spect_dens
//   squarer/compare datapath. Decodes SPECIAL2 UDI ops, drives the
//   datapath controls (mode registered into M) and runs the two-pass
//   SDACC op: RD = RS.hi^2 + RT.hi^2 + RS.lo^2 + RT.lo^2.
//
//   Ports:
//     UDI_gclk, UDI_greset (sync, active-high), UDI_gscanenable
//     udi          : core-side UDI bundle (slave modport)
//     dp_rs/dp_rt  : datapath operands (sampled at the edge ending E)
//     dp_thr_wr    : threshold write strobe
//     dp_sum_mode  : registered sum mode, applies in M
//     dp_res_sel   : registered result select, applies in M
//     dp_rd        : datapath result, valid in M
//     sched_busy   : FSM not IDLE
// ---------------------------------------------------------------------------
module udi_spect_sched
   import udi_spect_pkg::*;
(
   input  logic             UDI_gclk,
   input  logic             UDI_greset,
   input  logic             UDI_gscanenable,
   udi_spect_sched_if.slave udi,
   output logic [31:0]      dp_rs,
   output logic [15:0]      dp_rt,
   output logic             dp_thr_wr,
   output logic [1:0]       dp_sum_mode,
   output logic             dp_res_sel,
   input  logic [31:0]      dp_rd,
   output logic             sched_busy
);

   udi_dec_t     w_dec;
   sched_state_t w_state;
   sched_state_t w_state_d;
   logic         w_hit;
   logic         w_kill;
   logic         w_unused_ir;

   logic [1:0]   r_state;
   logic [2:0]   r_mode;      // {sum_mode, res_sel}
   logic [31:0]  r_lo;        // {rs.lo, rt.lo} held for the second pass
   logic [31:0]  r_acc;       // first-pass result

   logic         w_mode_ld;
   logic [2:0]   w_mode_d;
   logic         w_lo_ld;
   logic [31:0]  w_lo_d;
   logic         w_acc_ld;
   logic [31:0]  w_acc_d;

   assign w_unused_ir = ^udi.UDI_ir_e[25:6];

   udi_spect_decode u_decode (
      .i_funct (udi.UDI_ir_e[5:0]),
      .o_dec   (w_dec)
   );

   assign w_state = sched_state_t'(r_state);

   // A new op is only accepted while the sequencer is idle.
   assign w_hit  = udi.UDI_irvalid_e & udi.UDI_start_e
                 & (udi.UDI_ir_e[31:26] == MAJ_OP) & (w_state == ST_IDLE);
   assign w_kill = udi.UDI_kill_m & udi.UDI_run_m;

   // Next state; reset folds in here because the state cell has no reset.
   always_comb begin
      w_state_d = w_state;
      case (w_state)
         ST_IDLE: if (w_hit & w_dec.is_sdacc) w_state_d = ST_P2;
         ST_P2:   w_state_d = w_kill ? ST_IDLE : ST_FIN;
         ST_FIN:  w_state_d = ST_IDLE;
         default: w_state_d = ST_IDLE;
      endcase
      if (UDI_greset) w_state_d = ST_IDLE;
   end

   mvp_cregister_wide #(.WIDTH(2)) u_state_reg (
      .clk (UDI_gclk), .cond (1'b1), .scanen (UDI_gscanenable),
      .d   (w_state_d), .q (r_state)
   );

   // Mode registers hold unless a mapped op hits (SDACC loads SUM/CALC).
   assign w_mode_ld = UDI_greset | (w_hit & w_dec.load);
   assign w_mode_d  = UDI_greset ? {CTL_SUM_MODE_NONE, CTL_RES_CALC}
                                 : {w_dec.sum_mode, w_dec.res_sel};

   mvp_cregister_wide #(.WIDTH(3)) u_mode_reg (
      .clk (UDI_gclk), .cond (w_mode_ld), .scanen (UDI_gscanenable),
      .d   (w_mode_d), .q (r_mode)
   );

   assign w_lo_ld = UDI_greset | (w_hit & w_dec.is_sdacc);
   assign w_lo_d  = UDI_greset ? 32'd0 : {udi.UDI_rs_e[15:0], udi.UDI_rt_e[15:0]};

   mvp_cregister_wide #(.WIDTH(32)) u_lo_reg (
      .clk (UDI_gclk), .cond (w_lo_ld), .scanen (UDI_gscanenable),
      .d   (w_lo_d), .q (r_lo)
   );

   // First-pass result is captured at the end of P2 unless the op is killed.
   assign w_acc_ld = UDI_greset | ((w_state == ST_P2) & ~w_kill);
   assign w_acc_d  = UDI_greset ? 32'd0 : dp_rd;

   mvp_cregister_wide #(.WIDTH(32)) u_acc_reg (
      .clk (UDI_gclk), .cond (w_acc_ld), .scanen (UDI_gscanenable),
      .d   (w_acc_d), .q (r_acc)
   );

   // In P2 the lo halves go through the hi-half squarer path.
   assign dp_rs       = (w_state == ST_P2) ? {r_lo[31:16], 16'h0000} : udi.UDI_rs_e;
   assign dp_rt       = (w_state == ST_P2) ? r_lo[15:0] : udi.UDI_rt_e[31:16];
   assign dp_thr_wr   = w_hit & w_dec.thr_wr;
   assign dp_sum_mode = r_mode[2:1];
   assign dp_res_sel  = r_mode[0];

   assign udi.UDI_stall_m = (w_state == ST_P2) & ~w_kill;
   assign udi.UDI_rd_m    = (w_state == ST_FIN) ? (r_acc + dp_rd) : dp_rd;
   assign sched_busy      = (w_state != ST_IDLE);

endmodule

// File: tb/tb_udi_spect_sched.sv
// ---------------------------------------------------------------------------
// tb_udi_spect_sched
//   Bench for udi_spect_sched with a small behavioural datapath model and
//   a reference model computed directly from the op definitions.
// ---------------------------------------------------------------------------
module tb_udi_spect_sched;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scan_en = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] dp_rs;
   logic [15:0] dp_rt;
   logic        dp_thr_wr;
   logic [1:0]  dp_sum_mode;
   logic        dp_res_sel;
   logic [31:0] dp_rd;
   logic        sched_busy;

   udi_spect_sched_if u_if ();

   udi_spect_sched dut (
      .UDI_gclk        (clk),
      .UDI_greset      (rst),
      .UDI_gscanenable (scan_en),
      .udi             (u_if.slave),
      .dp_rs           (dp_rs),
      .dp_rt           (dp_rt),
      .dp_thr_wr       (dp_thr_wr),
      .dp_sum_mode     (dp_sum_mode),
      .dp_res_sel      (dp_res_sel),
      .dp_rd           (dp_rd),
      .sched_busy      (sched_busy)
   );

   // ---------------- datapath model ----------------
   // Operands/threshold sampled at the edge ending t; result combinational in t+1.
   logic [31:0] m_rs_q;
   logic [15:0] m_rt_q;
   logic [31:0] m_thr_q;

   always_ff @(posedge clk) begin
      m_rs_q <= dp_rs;
      m_rt_q <= dp_rt;
      if (rst)            m_thr_q <= 32'd0;
      else if (dp_thr_wr) m_thr_q <= dp_rs;
   end

   always_comb begin
      logic [32:0] a, b, s;
      logic [31:0] v;
      a = {17'd0, m_rs_q[31:16]};
      b = {17'd0, m_rt_q};
      s = a * a + b * b;
      case (dp_sum_mode)
         2'd1:    v = s[31:0];
         2'd2:    v = s[32:1];
         2'd3:    v = m_rs_q;
         default: v = 32'd0;
      endcase
      dp_rd = dp_res_sel ? {31'd0, (v >= m_thr_q)} : v;
   end

   // ---------------- scoreboard / reference ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   int          ref_fn = 0;        // funct of the op whose mode is currently held (0: none)
   logic [31:0] ref_thr = 32'd0;

   function automatic logic [1:0] exp_mode(int fn);
      case (fn)
         16, 20:  return 2'd1;
         17, 21:  return 2'd2;
         18, 22:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_calc(int fn, logic [31:0] rs, logic [31:0] rt, logic [31:0] thr);
      longint unsigned a, b, sq, val;
      a  = rs[31:16];
      b  = rt[31:16];
      sq = a * a + b * b;
      case (fn)
         16, 20:  val = sq % 64'h1_0000_0000;
         17, 21:  val = sq / 2;
         18, 22:  val = rs;
         default: val = 0;
      endcase
      if (fn >= 20 && fn <= 22) return (val >= thr) ? 32'd1 : 32'd0;
      return val[31:0];
   endfunction

   function automatic logic [31:0] ref_sdacc(logic [31:0] rs, logic [31:0] rt);
      longint unsigned sum;
      sum = longint'(rs[31:16]) * rs[31:16] + longint'(rt[31:16]) * rt[31:16]
          + longint'(rs[15:0]) * rs[15:0] + longint'(rt[15:0]) * rt[15:0];
      return sum[31:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      u_if.UDI_ir_e      = 32'd0;
      u_if.UDI_irvalid_e = 1'b0;
      u_if.UDI_start_e   = 1'b0;
      u_if.UDI_run_m     = 1'b1;
      u_if.UDI_kill_m    = 1'b0;
   endtask

   task automatic issue(input logic [5:0] maj, input logic [5:0] fn,
                        input logic [31:0] rs, input logic [31:0] rt, input logic valid);
      u_if.UDI_ir_e      = {maj, 20'($urandom), fn};
      u_if.UDI_rs_e      = rs;
      u_if.UDI_rt_e      = rt;
      u_if.UDI_irvalid_e = valid;
      u_if.UDI_start_e   = 1'b1;
   endtask

   // Single-pass (or non-hitting) instruction: E cycle, then M-stage checks.
   task automatic do_single(input logic [5:0] maj, input logic [5:0] fn,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic valid, output logic [31:0] obs);
      logic        hit;
      logic        exp_thr;
      logic [31:0] exp_rd;
      hit     = valid && (maj == 6'd28);
      exp_thr = hit && (fn == 6'd19);
      issue(maj, fn, rs, rt, valid);
      #1;
      n_cmp++;
      if (dp_thr_wr !== exp_thr) begin
         n_fail++; $display("FAIL single_thr_wr fn=%0d: got %b want %b", fn, dp_thr_wr, exp_thr);
      end
      if (hit && fn >= 6'd16 && fn <= 6'd22) ref_fn = int'(fn);
      exp_rd = ref_calc(ref_fn, rs, rt, ref_thr);
      if (exp_thr) ref_thr = rs;
      @(negedge clk);
      n_cmp++;
      if (u_if.UDI_rd_m !== exp_rd) begin
         n_fail++; $display("FAIL single_rd fn=%0d rs=%h rt=%h: got %h want %h", fn, rs, rt, u_if.UDI_rd_m, exp_rd);
      end
      n_cmp++;
      if (dp_sum_mode !== exp_mode(ref_fn) || dp_res_sel !== (ref_fn >= 20 && ref_fn <= 22)) begin
         n_fail++; $display("FAIL single_mode fn=%0d: got %0d/%b want %0d/%b", fn, dp_sum_mode, dp_res_sel,
                            exp_mode(ref_fn), (ref_fn >= 20 && ref_fn <= 22));
      end
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b0 || sched_busy !== 1'b0) begin
         n_fail++; $display("FAIL single_stall_busy: got %b/%b want 0/0", u_if.UDI_stall_m, sched_busy);
      end
      obs = u_if.UDI_rd_m;
      drive_idle();
   endtask

   // Full SDACC sequence: E, P2 (stalled M), FIN, back to IDLE.
   task automatic do_sdacc(input logic [31:0] rs, input logic [31:0] rt, output logic [31:0] obs);
      logic [31:0] exp_rd;
      exp_rd = ref_sdacc(rs, rt);
      issue(6'd28, 6'd23, rs, rt, 1'b1);
      #1;
      n_cmp++;
      if (dp_thr_wr !== 1'b0) begin
         n_fail++; $display("FAIL sdacc_thr_wr: got %b want 0", dp_thr_wr);
      end
      ref_fn = 16;
      @(negedge clk);
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b1 || sched_busy !== 1'b1 || dp_sum_mode !== 2'd1) begin
         n_fail++; $display("FAIL sdacc_p2: stall/busy/mode got %b/%b/%0d want 1/1/1", u_if.UDI_stall_m, sched_busy, dp_sum_mode);
      end
      drive_idle();
      @(negedge clk);
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b0 || sched_busy !== 1'b1) begin
         n_fail++; $display("FAIL sdacc_fin: stall/busy got %b/%b want 0/1", u_if.UDI_stall_m, sched_busy);
      end
      n_cmp++;
      if (u_if.UDI_rd_m !== exp_rd) begin
         n_fail++; $display("FAIL sdacc_rd rs=%h rt=%h: got %h want %h", rs, rt, u_if.UDI_rd_m, exp_rd);
      end
      obs = u_if.UDI_rd_m;
      @(negedge clk);
      n_cmp++;
      if (sched_busy !== 1'b0 || u_if.UDI_stall_m !== 1'b0) begin
         n_fail++; $display("FAIL sdacc_done: busy/stall got %b/%b want 0/0", sched_busy, u_if.UDI_stall_m);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive_idle();
      u_if.UDI_rs_e = 32'd0;
      u_if.UDI_rt_e = 32'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_fn  = 0;
      ref_thr = 32'd0;
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b0 || sched_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall_busy: got %b/%b want 0/0", u_if.UDI_stall_m, sched_busy);
      end
      n_cmp++;
      if (dp_sum_mode !== 2'd0 || dp_res_sel !== 1'b0 || dp_thr_wr !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl: mode/sel/thr got %0d/%b/%b want 0/0/0", dp_sum_mode, dp_res_sel, dp_thr_wr);
      end
      n_cmp++;
      if (u_if.UDI_rd_m !== 32'd0) begin
         n_fail++; $display("FAIL reset_rd: got %h want 0", u_if.UDI_rd_m);
      end
   endtask

   task automatic test_single();
      logic [31:0] obs;
      do_single(6'd28, 6'd16, 32'h0003_1234, 32'h0004_5678, 1'b1, obs);
      n_cmp++;
      if (obs !== 32'd25) begin
         n_fail++; $display("FAIL single_25: got %0d want 25", obs);
      end
      do_single(6'd28, 6'd17, 32'h0003_0000, 32'h0004_0000, 1'b1, obs);
      n_cmp++;
      if (obs !== 32'd12) begin
         n_fail++; $display("FAIL single_half: got %0d want 12", obs);
      end
      do_single(6'd28, 6'd18, 32'hCAFE_BABE, 32'h1111_2222, 1'b1, obs);
      do_single(6'd28, 6'd5,  32'h0002_0000, 32'h0002_0000, 1'b1, obs);  // unmapped: bypass held
   endtask

   task automatic test_sdacc();
      logic [31:0] obs;
      do_sdacc(32'h0003_0001, 32'h0004_0002, obs);
      n_cmp++;
      if (obs !== 32'd30) begin
         n_fail++; $display("FAIL sdacc_30: got %0d want 30", obs);
      end
      do_sdacc(32'hFFFF_FFFF, 32'hFFFF_FFFF, obs);
      n_cmp++;
      if (obs !== 32'hFFF8_0004) begin
         n_fail++; $display("FAIL sdacc_wrap: got %h want fff80004", obs);
      end
   endtask

   task automatic test_kill();
      logic [31:0] obs;
      issue(6'd28, 6'd23, 32'h0003_0001, 32'h0004_0002, 1'b1);
      ref_fn = 16;
      @(negedge clk);
      drive_idle();
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b1) begin
         n_fail++; $display("FAIL kill_p2_stall: got %b want 1", u_if.UDI_stall_m);
      end
      u_if.UDI_kill_m = 1'b1;
      u_if.UDI_run_m  = 1'b0;
      #1;
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b1) begin
         n_fail++; $display("FAIL kill_unqualified: stall got %b want 1", u_if.UDI_stall_m);
      end
      u_if.UDI_run_m = 1'b1;
      #1;
      n_cmp++;
      if (u_if.UDI_stall_m !== 1'b0) begin
         n_fail++; $display("FAIL kill_stall_drop: got %b want 0", u_if.UDI_stall_m);
      end
      @(negedge clk);
      u_if.UDI_kill_m = 1'b0;
      n_cmp++;
      if (sched_busy !== 1'b0 || u_if.UDI_stall_m !== 1'b0) begin
         n_fail++; $display("FAIL kill_idle: busy/stall got %b/%b want 0/0", sched_busy, u_if.UDI_stall_m);
      end
      ref_thr = ref_thr;
      do_single(6'd28, 6'd20, 32'h0005_0000, 32'h0001_0000, 1'b1, obs);
   endtask

   task automatic test_masked();
      logic [31:0] obs;
      logic [31:0] exp_rd;
      do_single(6'd28, 6'd19, 32'h0000_0100, 32'h0, 1'b1, obs);   // threshold 256
      exp_rd = ref_sdacc(32'h0001_0200, 32'h0002_0003);
      issue(6'd28, 6'd23, 32'h0001_0200, 32'h0002_0003, 1'b1);
      ref_fn = 16;
      @(negedge clk);
      issue(6'd28, 6'd19, 32'hDEAD_0000, 32'h0, 1'b1);             // arrives during P2
      #1;
      n_cmp++;
      if (dp_thr_wr !== 1'b0) begin
         n_fail++; $display("FAIL masked_thr_p2: got %b want 0", dp_thr_wr);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (dp_thr_wr !== 1'b0) begin
         n_fail++; $display("FAIL masked_thr_fin: got %b want 0", dp_thr_wr);
      end
      n_cmp++;
      if (u_if.UDI_rd_m !== exp_rd) begin
         n_fail++; $display("FAIL masked_rd: got %h want %h", u_if.UDI_rd_m, exp_rd);
      end
      drive_idle();
      @(negedge clk);
      // Threshold must still be 256: 16^2 meets it, 15^2 does not.
      do_single(6'd28, 6'd20, 32'h0010_0000, 32'h0, 1'b1, obs);
      n_cmp++;
      if (obs !== 32'd1) begin
         n_fail++; $display("FAIL thr_kept_hi: got %0d want 1", obs);
      end
      do_single(6'd28, 6'd20, 32'h000F_0000, 32'h0, 1'b1, obs);
      n_cmp++;
      if (obs !== 32'd0) begin
         n_fail++; $display("FAIL thr_kept_lo: got %0d want 0", obs);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] obs;
      issue(6'd28, 6'd23, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ref_fn  = 0;
      ref_thr = 32'd0;
      n_cmp++;
      if (sched_busy !== 1'b0 || u_if.UDI_stall_m !== 1'b0 || dp_sum_mode !== 2'd0) begin
         n_fail++; $display("FAIL reset_mid: busy/stall/mode got %b/%b/%0d want 0/0/0", sched_busy, u_if.UDI_stall_m, dp_sum_mode);
      end
      n_cmp++;
      if (u_if.UDI_rd_m !== 32'd0) begin
         n_fail++; $display("FAIL reset_mid_rd: got %h want 0", u_if.UDI_rd_m);
      end
      do_single(6'd28, 6'd21, 32'h0100_0000, 32'h0, 1'b1, obs);
   endtask

   task automatic test_random();
      logic [31:0] obs;
      for (int i = 0; i < 60; i++) begin
         int          r;
         logic [31:0] rs, rt;
         logic [5:0]  fn, maj;
         logic        valid;
         r     = $urandom_range(0, 9);
         rs    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         rt    = $urandom;
         maj   = (r == 8) ? 6'd27 : 6'd28;
         valid = (r == 9) ? 1'b0 : 1'b1;
         fn    = (r == 7) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 23));
         if (r < 2) begin
            do_sdacc(rs, rt, obs);
         end else if (r == 2) begin
            do_single(6'd28, 6'd19, rs, rt, 1'b1, obs);
         end else if (fn == 6'd23 && valid && maj == 6'd28) begin
            do_sdacc(rs, rt, obs);
         end else begin
            do_single(maj, fn, rs, rt, valid, obs);
         end
      end
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      drive_idle();
      u_if.UDI_rs_e = 32'd0;
      u_if.UDI_rt_e = 32'd0;
      test_reset();
      test_single();
      test_sdacc();
      test_kill();
      test_masked();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
